// File: rtl/roce_meta_pkg.sv
// Field layout, constants and decode helpers shared by the RoCE tx meta tracker.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package roce_meta_pkg;

  // Tx meta command layout (bit offsets within tdata)
  localparam int META_OP_LSB    = 0;
  localparam int META_OP_W      = 3;
  localparam int META_QPN_LSB   = 3;
  localparam int META_QPN_W     = 24;
  localparam int META_LADDR_LSB = 27;
  localparam int META_LADDR_W   = 48;
  localparam int META_RADDR_LSB = 75;
  localparam int META_RADDR_W   = 48;
  localparam int META_LEN_LSB   = 123;
  localparam int META_LEN_W     = 32;
  localparam int META_FIELDS_W  = META_LEN_LSB + META_LEN_W;

  // Tx status layout (bit offsets within tdata)
  localparam int STATUS_OP_LSB   = 0;
  localparam int STATUS_OP_W     = 3;
  localparam int STATUS_QPN_LSB  = 3;
  localparam int STATUS_QPN_W    = 24;
  localparam int STATUS_CODE_LSB = 27;
  localparam int STATUS_CODE_W   = 8;
  localparam int STATUS_FIELDS_W = STATUS_CODE_LSB + STATUS_CODE_W;

  localparam logic [META_OP_W-1:0]     OP_RDMA_WRITE = 3'b001;
  localparam logic [STATUS_CODE_W-1:0] STATUS_OK     = 8'h00;

  // Declared MSB first so the struct overlays the low META_FIELDS_W bits of tdata
  typedef struct packed {
    logic [META_LEN_W-1:0]   len;
    logic [META_RADDR_W-1:0] raddr;
    logic [META_LADDR_W-1:0] laddr;
    logic [META_QPN_W-1:0]   qpn;
    logic [META_OP_W-1:0]    op;
  } meta_fields_t;

  function automatic meta_fields_t decode_meta(input logic [META_FIELDS_W-1:0] raw);
    return meta_fields_t'(raw);
  endfunction

  function automatic logic [STATUS_CODE_W-1:0] status_code(input logic [STATUS_FIELDS_W-1:0] raw);
    return raw[STATUS_CODE_LSB +: STATUS_CODE_W];
  endfunction

endpackage

// File: rtl/tx_len_fifo.sv
// Synchronous FIFO holding the len of every issued, not yet retired command.
// Latency: push visible at the head on the next cycle; at empty a simultaneous pop sees the pushed word directly.
// Backpressure: none internally; full/empty/count exported, push+pop together is legal at full and at empty.
module tx_len_fifo
  import roce_meta_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             bypass;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // At empty a push+pop passes the word straight through and leaves the FIFO empty
  assign bypass = empty && push && pop;
  assign wr_en  = push && !bypass && (!full || pop);
  assign rd_en  = pop && !empty;
  assign rd_dat = empty ? wr_dat : mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care while their slot is unoccupied
  always_ff @(posedge ap_clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/roce_tx_meta_tracker.sv
// Forwards tx meta commands through a 2-entry skid slice, caps commands in flight, retires them on status beats and keeps debug counters.
// Latency: 1 cycle s_axis_meta handshake to m_axis_meta_tvalid; counters update on the edge after the status beat.
// Backpressure: s_axis_meta_tready is registered (no comb path from m tready); status is never back-pressured.
module roce_tx_meta_tracker
  import roce_meta_pkg::*;
#(
  parameter int META_W          = 256,
  parameter int STATUS_W        = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                               ap_clk,
  input  logic                               ap_rst_n,

  input  logic                               s_axis_meta_tvalid,
  output logic                               s_axis_meta_tready,
  input  logic [META_W-1:0]                  s_axis_meta_tdata,
  input  logic [META_W/8-1:0]                s_axis_meta_tkeep,
  input  logic                               s_axis_meta_tlast,

  output logic                               m_axis_meta_tvalid,
  input  logic                               m_axis_meta_tready,
  output logic [META_W-1:0]                  m_axis_meta_tdata,
  output logic [META_W/8-1:0]                m_axis_meta_tkeep,
  output logic                               m_axis_meta_tlast,

  input  logic                               s_axis_status_tvalid,
  output logic                               s_axis_status_tready,
  input  logic [STATUS_W-1:0]                s_axis_status_tdata,
  input  logic [STATUS_W/8-1:0]              s_axis_status_tkeep,
  input  logic                               s_axis_status_tlast,

  input  logic                               clear,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic [31:0]                        completed_cnt,
  output logic [31:0]                        error_cnt,
  output logic [63:0]                        bytes_done,
  output logic                               err_pulse,
  output logic                               underflow
);

  localparam int OW     = $clog2(MAX_OUTSTANDING) + 1;
  localparam int SLOT_W = META_W + META_W/8 + 1;
  localparam logic [OW:0]   CAP       = (OW+1)'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] DEPTH_CNT = OW'(MAX_OUTSTANDING);

  // Skid slice state: slot0 is always the head presented downstream
  logic [SLOT_W-1:0] slot0;
  logic [SLOT_W-1:0] slot1;
  logic [SLOT_W-1:0] s_slot;
  logic [1:0]        occ;
  logic [1:0]        occ_nxt;
  logic [1:0]        wr_idx;
  logic              tready_q;
  logic              tready_nxt;
  logic              s_hs;
  logic              m_hs;

  // Accounting
  logic                      issue;
  logic                      status_hs;
  logic                      retire;
  logic                      status_ok;
  logic [STATUS_CODE_W-1:0]  code;
  meta_fields_t              issue_fields;
  logic [OW-1:0]             out_nxt;
  logic [OW:0]               occupied;

  // Length FIFO
  logic [META_LEN_W-1:0]     fifo_rd_dat;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [OW-1:0]             fifo_cnt;
  logic [OW-1:0]             fifo_cnt_nxt;

  logic                      unused_ok;

  assign s_slot             = {s_axis_meta_tlast, s_axis_meta_tkeep, s_axis_meta_tdata};
  assign m_axis_meta_tvalid = (occ != 2'd0);
  assign m_axis_meta_tdata  = slot0[META_W-1:0];
  assign m_axis_meta_tkeep  = slot0[META_W +: META_W/8];
  assign m_axis_meta_tlast  = slot0[SLOT_W-1];
  assign s_axis_meta_tready = tready_q;

  assign s_hs = s_axis_meta_tvalid && tready_q;
  assign m_hs = m_axis_meta_tvalid && m_axis_meta_tready;

  assign s_axis_status_tready = 1'b1;
  assign status_hs    = s_axis_status_tvalid;
  assign retire       = status_hs && (outstanding != '0);
  assign issue        = m_hs;
  assign issue_fields = decode_meta(m_axis_meta_tdata[META_FIELDS_W-1:0]);
  assign code         = status_code(s_axis_status_tdata[STATUS_FIELDS_W-1:0]);
  assign status_ok    = (code == STATUS_OK);

  // Next-state of slice occupancy, outstanding and FIFO fill, feeding the registered tready
  always_comb begin
    occ_nxt = occ;
    if (s_hs && !m_hs)      occ_nxt = occ + 2'd1;
    else if (!s_hs && m_hs) occ_nxt = occ - 2'd1;

    // slot that an accepted beat lands in, after any head departure this cycle
    wr_idx = m_hs ? (occ - 2'd1) : occ;

    out_nxt = outstanding;
    if (issue && !retire)      out_nxt = outstanding + OW'(1);
    else if (!issue && retire) out_nxt = outstanding - OW'(1);

    fifo_cnt_nxt = fifo_cnt;
    if (issue && !retire)      fifo_cnt_nxt = fifo_cnt + OW'(1);
    else if (!issue && retire) fifo_cnt_nxt = fifo_cnt - OW'(1);

    // beats held in the slice count against the cap so they can always be issued
    occupied   = (OW+1)'(out_nxt) + (OW+1)'(occ_nxt);
    tready_nxt = (occ_nxt != 2'd2) && (occupied < CAP) && (fifo_cnt_nxt < DEPTH_CNT);
  end

  // Slice control registers
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      occ      <= 2'd0;
      tready_q <= 1'b0;
    end else begin
      occ      <= occ_nxt;
      tready_q <= tready_nxt;
    end
  end

  // Slice data: head only changes when it departs or the slice is empty, so tdata holds under stall
  always_ff @(posedge ap_clk) begin
    if (m_hs && (occ == 2'd2)) slot0 <= slot1;
    if (s_hs) begin
      if (wr_idx == 2'd0) slot0 <= s_slot;
      else                slot1 <= s_slot;
    end
  end

  tx_len_fifo #(
    .WIDTH (META_LEN_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_len_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .push     (issue),
    .wr_dat   (issue_fields.len),
    .pop      (retire),
    .rd_dat   (fifo_rd_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );

  // In-flight count
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) outstanding <= '0;
    else           outstanding <= out_nxt;
  end

  // Debug counters; clear overrides any same-cycle increment
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      completed_cnt <= 32'd0;
      error_cnt     <= 32'd0;
      bytes_done    <= 64'd0;
      underflow     <= 1'b0;
      err_pulse     <= 1'b0;
    end else begin
      err_pulse <= retire && !status_ok;
      if (clear) begin
        completed_cnt <= 32'd0;
        error_cnt     <= 32'd0;
        bytes_done    <= 64'd0;
        underflow     <= 1'b0;
      end else begin
        if (retire && status_ok) begin
          completed_cnt <= completed_cnt + 32'd1;
          bytes_done    <= bytes_done + {32'd0, fifo_rd_dat};
        end
        if (retire && !status_ok) error_cnt <= error_cnt + 32'd1;
        if (status_hs && (outstanding == '0)) underflow <= 1'b1;
      end
    end
  end

  // Fields carried for observation only
  assign unused_ok = ^{s_axis_status_tkeep, s_axis_status_tlast, s_axis_status_tdata,
                       issue_fields.raddr, issue_fields.laddr, issue_fields.qpn,
                       (issue_fields.op == OP_RDMA_WRITE), fifo_full, fifo_empty};

endmodule

// File: tb/tb_roce_tx_meta_tracker.sv
// Randomized and directed bench for roce_tx_meta_tracker against a queue/count reference model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: m tready driven randomly; status only withheld, never back-pressured.
module tb_roce_tx_meta_tracker;

  localparam int META_W   = 256;
  localparam int STATUS_W = 512;
  localparam int MAXO     = 16;
  localparam int OW       = 5;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic                  s_axis_meta_tvalid = 1'b0;
  logic                  s_axis_meta_tready;
  logic [META_W-1:0]     s_axis_meta_tdata = '0;
  logic [META_W/8-1:0]   s_axis_meta_tkeep = '0;
  logic                  s_axis_meta_tlast = 1'b0;
  logic                  m_axis_meta_tvalid;
  logic                  m_axis_meta_tready = 1'b0;
  logic [META_W-1:0]     m_axis_meta_tdata;
  logic [META_W/8-1:0]   m_axis_meta_tkeep;
  logic                  m_axis_meta_tlast;
  logic                  s_axis_status_tvalid = 1'b0;
  logic                  s_axis_status_tready;
  logic [STATUS_W-1:0]   s_axis_status_tdata = '0;
  logic [STATUS_W/8-1:0] s_axis_status_tkeep = '1;
  logic                  s_axis_status_tlast = 1'b1;
  logic                  clear = 1'b0;
  logic [OW-1:0]         outstanding;
  logic [31:0]           completed_cnt;
  logic [31:0]           error_cnt;
  logic [63:0]           bytes_done;
  logic                  err_pulse;
  logic                  underflow;

  roce_tx_meta_tracker #(
    .META_W (META_W), .STATUS_W (STATUS_W), .MAX_OUTSTANDING (MAXO)
  ) dut (
    .ap_clk (ap_clk), .ap_rst_n (ap_rst_n),
    .s_axis_meta_tvalid (s_axis_meta_tvalid), .s_axis_meta_tready (s_axis_meta_tready),
    .s_axis_meta_tdata (s_axis_meta_tdata), .s_axis_meta_tkeep (s_axis_meta_tkeep),
    .s_axis_meta_tlast (s_axis_meta_tlast),
    .m_axis_meta_tvalid (m_axis_meta_tvalid), .m_axis_meta_tready (m_axis_meta_tready),
    .m_axis_meta_tdata (m_axis_meta_tdata), .m_axis_meta_tkeep (m_axis_meta_tkeep),
    .m_axis_meta_tlast (m_axis_meta_tlast),
    .s_axis_status_tvalid (s_axis_status_tvalid), .s_axis_status_tready (s_axis_status_tready),
    .s_axis_status_tdata (s_axis_status_tdata), .s_axis_status_tkeep (s_axis_status_tkeep),
    .s_axis_status_tlast (s_axis_status_tlast),
    .clear (clear), .outstanding (outstanding), .completed_cnt (completed_cnt),
    .error_cnt (error_cnt), .bytes_done (bytes_done), .err_pulse (err_pulse),
    .underflow (underflow)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef logic [META_W+META_W/8:0] beat_t;
  beat_t       sb[$];          // beats accepted upstream, not yet issued
  logic [31:0] mdl_lens[$];    // len of issued, unretired commands, oldest first
  int          mdl_out   = 0;
  logic [31:0] mdl_comp  = '0;
  logic [31:0] mdl_err   = '0;
  logic [63:0] mdl_bytes = '0;
  bit          mdl_uf    = 0;
  bit          mdl_ep    = 0;
  bit          stall_q   = 0;
  beat_t       stall_beat;

  always @(negedge ap_clk) begin : mon
    beat_t       mb;
    logic [31:0] ln;
    bit          st;
    bit          ret;
    bit          new_ep;
    bit          iss;
    logic [7:0]  cd;
    // outputs vs model state after the last edge
    check_eq("outstanding", outstanding, mdl_out);
    check_eq("completed_cnt", completed_cnt, mdl_comp);
    check_eq("error_cnt", error_cnt, mdl_err);
    check_eq("bytes_done", bytes_done, mdl_bytes);
    check_eq("underflow", underflow, mdl_uf);
    check_eq("err_pulse", err_pulse, mdl_ep);
    check_eq("status_tready", s_axis_status_tready, 1'b1);
    check_eq("m_tvalid", m_axis_meta_tvalid, sb.size() != 0);
    if (stall_q) begin
      check_eq("stall_tvalid", m_axis_meta_tvalid, 1'b1);
      check_eq("stall_tdata", m_axis_meta_tdata, stall_beat[META_W-1:0]);
      check_eq("stall_keep_last", {m_axis_meta_tlast, m_axis_meta_tkeep}, stall_beat[META_W+META_W/8:META_W]);
    end
    if (s_axis_meta_tready)
      check_eq("cap_respected", (mdl_out + sb.size() < MAXO) && (sb.size() < 2), 1'b1);

    // advance model for the coming edge
    if (!ap_rst_n) begin
      sb.delete(); mdl_lens.delete();
      mdl_out = 0; mdl_comp = '0; mdl_err = '0; mdl_bytes = '0;
      mdl_uf = 0; mdl_ep = 0; stall_q = 0;
    end else begin
      iss = m_axis_meta_tvalid && m_axis_meta_tready;
      stall_q = m_axis_meta_tvalid && !m_axis_meta_tready;
      stall_beat = {m_axis_meta_tlast, m_axis_meta_tkeep, m_axis_meta_tdata};
      if (iss) begin
        check_eq("issue_has_beat", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mb = sb.pop_front();
          check_eq("issue_tdata", m_axis_meta_tdata, mb[META_W-1:0]);
          check_eq("issue_keep_last", {m_axis_meta_tlast, m_axis_meta_tkeep}, mb[META_W+META_W/8:META_W]);
        end
      end
      if (s_axis_meta_tvalid && s_axis_meta_tready)
        sb.push_back({s_axis_meta_tlast, s_axis_meta_tkeep, s_axis_meta_tdata});
      st = s_axis_status_tvalid;
      cd = s_axis_status_tdata[34:27];
      ret = st && (mdl_out > 0);
      new_ep = 0;
      if (ret) begin
        ln = mdl_lens.pop_front();
        if (cd == 8'h00) begin
          mdl_comp  = mdl_comp + 32'd1;
          mdl_bytes = mdl_bytes + {32'd0, ln};
        end else begin
          mdl_err = mdl_err + 32'd1;
          new_ep  = 1;
        end
      end
      if (st && mdl_out == 0) mdl_uf = 1;
      if (iss) begin
        mdl_lens.push_back(m_axis_meta_tdata[154:123]);
        mdl_out++;
      end
      if (ret) mdl_out--;
      if (clear) begin
        mdl_comp = '0; mdl_err = '0; mdl_bytes = '0; mdl_uf = 0;
      end
      mdl_ep = new_ep;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [META_W-1:0] make_meta(input logic [31:0] len);
    logic [META_W-1:0] v;
    for (int i = 0; i < META_W/32; i++) v[i*32 +: 32] = $urandom;
    v[154:123] = len;
    v[2:0]     = 3'b001;
    return v;
  endfunction

  function automatic logic [STATUS_W-1:0] make_status(input logic [7:0] cd);
    logic [STATUS_W-1:0] v;
    for (int i = 0; i < STATUS_W/32; i++) v[i*32 +: 32] = $urandom;
    v[34:27] = cd;
    return v;
  endfunction

  // one beat, held until accepted; starts and ends just after a rising edge
  task automatic send_meta(input logic [META_W-1:0] d);
    bit ok;
    ok = 0;
    s_axis_meta_tvalid = 1'b1;
    s_axis_meta_tdata  = d;
    s_axis_meta_tkeep  = $urandom;
    s_axis_meta_tlast  = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge ap_clk);
      ok = s_axis_meta_tready;
      tick();
    end
    s_axis_meta_tvalid = 1'b0;
    check_eq("send_timeout", ok, 1'b1);
  endtask

  task automatic send_status(input logic [7:0] cd);
    s_axis_status_tvalid = 1'b1;
    s_axis_status_tdata  = make_status(cd);
    tick();
    s_axis_status_tvalid = 1'b0;
  endtask

  // keep offering beats for a fixed number of cycles, counting acceptances up to limit
  task automatic feed(input int cycles, input int limit, inout int n);
    bit hs;
    for (int c = 0; c < cycles; c++) begin
      if (n < limit && !s_axis_meta_tvalid) begin
        s_axis_meta_tvalid = 1'b1;
        s_axis_meta_tdata  = make_meta($urandom);
      end
      @(negedge ap_clk);
      hs = s_axis_meta_tvalid && s_axis_meta_tready;
      tick();
      if (hs) begin
        n++;
        s_axis_meta_tvalid = 1'b0;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  n;
    bit  hs;
    logic [META_W-1:0] d;

    // reset
    repeat (3) tick();
    @(negedge ap_clk);
    check_eq("rst_m_tvalid", m_axis_meta_tvalid, 1'b0);
    check_eq("rst_s_tready", s_axis_meta_tready, 1'b0);
    tick();
    ap_rst_n = 1'b1;
    tick();
    @(negedge ap_clk);
    check_eq("tready_after_rst", s_axis_meta_tready, 1'b1);
    tick();

    // single meta then one good status
    m_axis_meta_tready = 1'b1;
    d = make_meta(32'd4096);
    send_meta(d);
    @(negedge ap_clk);
    check_eq("single_tvalid", m_axis_meta_tvalid, 1'b1);
    check_eq("single_tdata", m_axis_meta_tdata, d);
    tick();
    @(negedge ap_clk);
    check_eq("single_out", outstanding, 5'd1);
    tick();
    send_status(8'h00);
    @(negedge ap_clk);
    check_eq("single_out0", outstanding, 5'd0);
    check_eq("single_comp", completed_cnt, 32'd1);
    check_eq("single_bytes", bytes_done, 64'd4096);
    tick();

    // cap: 20 offered with status withheld
    n = 0;
    feed(40, 20, n);
    @(negedge ap_clk);
    check_eq("cap_accepted", n, 16);
    check_eq("cap_out", outstanding, 5'd16);
    check_eq("cap_tready", s_axis_meta_tready, 1'b0);
    tick();
    s_axis_status_tvalid = 1'b1;
    s_axis_status_tdata  = make_status(8'h00);
    feed(1, 20, n);
    s_axis_status_tvalid = 1'b0;
    feed(10, 20, n);
    @(negedge ap_clk);
    check_eq("cap_accepted2", n, 17);
    check_eq("cap_out2", outstanding, 5'd16);
    tick();
    s_axis_meta_tvalid = 1'b0;
    repeat (16) send_status(8'h00);
    repeat (2) tick();
    @(negedge ap_clk);
    check_eq("cap_drained", outstanding, 5'd0);
    tick();

    // issue and retire in the same cycle at outstanding=5
    repeat (5) send_meta(make_meta($urandom_range(1, 9000)));
    repeat (2) tick();
    m_axis_meta_tready = 1'b0;
    send_meta(make_meta(32'd64));
    @(negedge ap_clk);
    check_eq("same_pre_out", outstanding, 5'd5);
    tick();
    m_axis_meta_tready = 1'b1;
    send_status(8'h00);
    @(negedge ap_clk);
    check_eq("same_out", outstanding, 5'd5);
    tick();
    repeat (5) send_status(8'h00);
    tick();

    // error status, then underflow held until clear
    clear = 1'b1;
    tick();
    clear = 1'b0;
    send_meta(make_meta(32'd777));
    repeat (2) tick();
    send_status(8'h03);
    @(negedge ap_clk);
    check_eq("err_cnt", error_cnt, 32'd1);
    check_eq("err_pulse_hi", err_pulse, 1'b1);
    check_eq("err_bytes", bytes_done, 64'd0);
    tick();
    @(negedge ap_clk);
    check_eq("err_pulse_lo", err_pulse, 1'b0);
    tick();
    send_status(8'h00);
    @(negedge ap_clk);
    check_eq("uf_set", underflow, 1'b1);
    repeat (2) tick();
    @(negedge ap_clk);
    check_eq("uf_hold", underflow, 1'b1);
    check_eq("uf_no_comp", completed_cnt, 32'd0);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    @(negedge ap_clk);
    check_eq("uf_clear", underflow, 1'b0);
    tick();

    // randomized traffic: 100 metas, random stalls, statuses and occasional clear
    n = 0;
    for (int cyc = 0; cyc < 4000 && n < 100; cyc++) begin
      m_axis_meta_tready = 1'($urandom_range(0, 1));
      if (!s_axis_meta_tvalid && $urandom_range(0, 3) != 0) begin
        s_axis_meta_tvalid = 1'b1;
        s_axis_meta_tdata  = make_meta($urandom);
        s_axis_meta_tkeep  = $urandom;
        s_axis_meta_tlast  = 1'($urandom_range(0, 1));
      end
      s_axis_status_tvalid = ($urandom_range(0, 9) < 4) && (mdl_out > 0);
      s_axis_status_tdata  = make_status(($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      clear = ($urandom_range(0, 49) == 0);
      @(negedge ap_clk);
      hs = s_axis_meta_tvalid && s_axis_meta_tready;
      tick();
      if (hs) begin
        n++;
        s_axis_meta_tvalid = 1'b0;
      end
    end
    s_axis_meta_tvalid = 1'b0;
    s_axis_status_tvalid = 1'b0;
    clear = 1'b0;
    check_eq("rand_accepted", n, 100);
    m_axis_meta_tready = 1'b1;
    for (int i = 0; i < 200 && (mdl_out > 0 || sb.size() > 0); i++) begin
      s_axis_status_tvalid = (mdl_out > 0);
      s_axis_status_tdata  = make_status(8'h00);
      tick();
    end
    s_axis_status_tvalid = 1'b0;
    @(negedge ap_clk);
    check_eq("rand_drained", outstanding, 5'd0);
    tick();

    // reset with 8 outstanding and the slice full
    repeat (8) send_meta(make_meta($urandom_range(1, 5000)));
    repeat (2) tick();
    m_axis_meta_tready = 1'b0;
    send_meta(make_meta(32'd10));
    send_meta(make_meta(32'd20));
    @(negedge ap_clk);
    check_eq("rst_pre_out", outstanding, 5'd8);
    check_eq("rst_pre_tvalid", m_axis_meta_tvalid, 1'b1);
    check_eq("rst_pre_tready", s_axis_meta_tready, 1'b0);
    tick();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_eq("rst_m_tvalid2", m_axis_meta_tvalid, 1'b0);
    check_eq("rst_s_tready2", s_axis_meta_tready, 1'b0);
    check_eq("rst_out", outstanding, 5'd0);
    check_eq("rst_comp", completed_cnt, 32'd0);
    check_eq("rst_err", error_cnt, 32'd0);
    check_eq("rst_bytes", bytes_done, 64'd0);
    check_eq("rst_err_pulse", err_pulse, 1'b0);
    check_eq("rst_uf", underflow, 1'b0);
    tick();
    m_axis_meta_tready = 1'b1;
    @(negedge ap_clk);
    check_eq("rst_tready_back", s_axis_meta_tready, 1'b1);
    tick();
    send_status(8'h00);
    @(negedge ap_clk);
    check_eq("rst_status_uf", underflow, 1'b1);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
